// File: rtl/register_file_if.sv
// Bus bundle for the register file: one write port, two combinational read
// ports and the sequential-clear handshake.
interface register_file_if #(
    parameter int N = 32
) ();
    logic         wr_ena;
    logic [4:0]   wr_addr;
    logic [N-1:0] wr_data;
    logic [4:0]   rd_addr0;
    logic [N-1:0] rd_data0;
    logic [4:0]   rd_addr1;
    logic [N-1:0] rd_data1;
    logic         clr_req;
    logic         busy;
    logic         clr_done;

    modport master (
        output wr_ena, wr_addr, wr_data, rd_addr0, rd_addr1, clr_req,
        input  rd_data0, rd_data1, busy, clr_done
    );

    modport slave (
        input  wr_ena, wr_addr, wr_data, rd_addr0, rd_addr1, clr_req,
        output rd_data0, rd_data1, busy, clr_done
    );
endinterface

// File: rtl/register_file.sv
// 32 x N register file with two combinational read ports, one write port
// and a sequential clear that zeroes entries 1..31, one per cycle.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | writes accepted; clr_req starts a clear (counter loads 1)
// CLEARING | entry[counter] zeroed each edge; writes and clr_req dropped
module register_file #(
    parameter int N = 32
) (
    input logic             clk,
    input logic             rst,
    register_file_if.slave  bus
);

    typedef enum logic {
        IDLE     = 1'b0,
        CLEARING = 1'b1
    } state_t;

    state_t       state_q, state_d;
    logic [4:0]   cnt_q, cnt_d;
    logic         clr_done_q, clr_done_d;
    logic [N-1:0] mem_q [32];
    logic [N-1:0] mem_d [32];

    // Next-state, clear counter, storage update and done pulse
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        clr_done_d = 1'b0;
        mem_d      = mem_q;
        case (state_q)
            IDLE: begin
                // A write in the same cycle as clr_req still commits; the
                // clear that follows will zero it later.
                if (bus.wr_ena && bus.wr_addr != 5'd0) begin
                    mem_d[bus.wr_addr] = bus.wr_data;
                end
                if (bus.clr_req) begin
                    state_d = CLEARING;
                    cnt_d   = 5'd1;
                end
            end
            CLEARING: begin
                mem_d[cnt_q] = '0;
                if (cnt_q == 5'd31) begin
                    state_d    = IDLE;
                    cnt_d      = 5'd0;
                    clr_done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
        endcase
        // Entry 0 is hardwired to zero.
        mem_d[0] = '0;
    end

    // State, counter, done pulse and storage flops; reset clears everything
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= 5'd0;
            clr_done_q <= 1'b0;
            for (int i = 0; i < 32; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            clr_done_q <= clr_done_d;
            mem_q      <= mem_d;
        end
    end

    assign bus.rd_data0 = mem_q[bus.rd_addr0];
    assign bus.rd_data1 = mem_q[bus.rd_addr1];
    assign bus.busy     = (state_q == CLEARING);
    assign bus.clr_done = clr_done_q;

endmodule

// File: tb/tb_register_file.sv
// Randomized scoreboard bench for register_file. The stimulus process pushes
// the expected outputs of each cycle; a monitor pops and compares them at the
// falling edge.
module tb_register_file;
    localparam int N = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    register_file_if #(.N(N)) bus ();

    register_file #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [N-1:0] r0;
        logic [N-1:0] r1;
        logic         busy;
        logic         done;
        int           id;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc_id = 0;

    // Reference model: contents, cycles of clear remaining, done flag
    logic [N-1:0] m_mem [32];
    int           clr_left;
    bit           done_f;

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_mem[i] = '0;
        clr_left = 0;
        done_f   = 1'b0;
    endtask

    function automatic logic [N-1:0] m_rd(input logic [4:0] a);
        return (a == 5'd0) ? '0 : m_mem[a];
    endfunction

    // One clock cycle: drive inputs, push expectation, advance model at edge
    task automatic cyc(input bit r, input bit we, input logic [4:0] wa,
                       input logic [N-1:0] wd, input logic [4:0] a0,
                       input logic [4:0] a1, input bit cr);
        exp_t e;
        rst          = r;
        bus.wr_ena   = we;
        bus.wr_addr  = wa;
        bus.wr_data  = wd;
        bus.rd_addr0 = a0;
        bus.rd_addr1 = a1;
        bus.clr_req  = cr;
        if (!r) model_reset();
        e.r0   = m_rd(a0);
        e.r1   = m_rd(a1);
        e.busy = (clr_left > 0);
        e.done = done_f;
        e.id   = cyc_id;
        sb.push_back(e);
        cyc_id++;
        @(posedge clk);
        if (!r) begin
            model_reset();
        end else if (clr_left == 0) begin
            done_f = 1'b0;
            if (we && wa != 5'd0) m_mem[wa] = wd;
            if (cr) clr_left = 31;
        end else begin
            m_mem[32 - clr_left] = '0;
            clr_left--;
            done_f = (clr_left == 0);
        end
        #1;
    endtask

    task automatic rnd_rd(input bit we, input logic [4:0] wa,
                          input logic [N-1:0] wd, input bit cr);
        cyc(1'b1, we, wa, wd, 5'($urandom), 5'($urandom), cr);
    endtask

    task automatic fill();
        for (int i = 1; i < 32; i++) rnd_rd(1'b1, 5'(i), N'(i), 1'b0);
    endtask

    task automatic chk(input string name, input int id,
                       input logic [N-1:0] act, input logic [N-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, id, act, exp);
        end
    endtask

    // Monitor: compare DUT outputs against the oldest pending expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("rd_data0", e.id, bus.rd_data0, e.r0);
                chk("rd_data1", e.id, bus.rd_data1, e.r1);
                chk("busy", e.id, N'(bus.busy), N'(e.busy));
                chk("clr_done", e.id, N'(bus.clr_done), N'(e.done));
            end
        end
    end

    initial begin
        bus.wr_ena = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.rd_addr0 = '0; bus.rd_addr1 = '0; bus.clr_req = 1'b0;
        model_reset();
        @(posedge clk);
        #1;

        // Reset held: writes ignored, reads zero
        cyc(1'b0, 1'b1, 5'd5, 32'hFFFF_FFFF, 5'd5, 5'd31, 1'b0);
        cyc(1'b0, 1'b1, 5'd6, 32'h1234_0000, 5'd6, 5'd5, 1'b1);

        // Write 5, read in write cycle (old) and next cycle (new)
        cyc(1'b1, 1'b1, 5'd5, 32'hDEAD_BEEF, 5'd0, 5'd5, 1'b0);
        cyc(1'b1, 1'b0, 5'd0, '0, 5'd5, 5'd5, 1'b0);

        // Entry 0 never written
        cyc(1'b1, 1'b1, 5'd0, 32'h1234_5678, 5'd0, 5'd0, 1'b0);
        cyc(1'b1, 1'b0, 5'd0, '0, 5'd0, 5'd0, 1'b0);

        // Full clear: watch the entry being cleared and the one just cleared
        fill();
        rnd_rd(1'b0, 5'd0, '0, 1'b1);
        for (int i = 0; i < 31; i++)
            cyc(1'b1, 1'b0, 5'd0, '0, 5'(i + 1), 5'(i), 1'b0);
        for (int i = 0; i < 4; i++) rnd_rd(1'b0, 5'd0, '0, 1'b0);

        // Write during clear at counter 3 is dropped
        fill();
        rnd_rd(1'b0, 5'd0, '0, 1'b1);
        rnd_rd(1'b0, 5'd0, '0, 1'b0);
        rnd_rd(1'b0, 5'd0, '0, 1'b0);
        cyc(1'b1, 1'b1, 5'd7, 32'hA5A5_A5A5, 5'd7, 5'd3, 1'b1);
        for (int i = 0; i < 30; i++) cyc(1'b1, 1'b0, 5'd0, '0, 5'd7, 5'($urandom), 1'b0);
        cyc(1'b1, 1'b0, 5'd0, '0, 5'd7, 5'd7, 1'b0);

        // Reset at counter 10 aborts clear; first post-reset edge writes
        fill();
        rnd_rd(1'b0, 5'd0, '0, 1'b1);
        for (int i = 0; i < 9; i++) rnd_rd(1'b0, 5'd0, '0, 1'b0);
        cyc(1'b0, 1'b0, 5'd0, '0, 5'd20, 5'd31, 1'b0);
        cyc(1'b1, 1'b1, 5'd3, 32'h0000_0333, 5'd25, 5'd3, 1'b0);
        cyc(1'b1, 1'b0, 5'd0, '0, 5'd3, 5'd30, 1'b0);

        // Write and clear in the same cycle
        fill();
        cyc(1'b1, 1'b1, 5'd9, 32'h1, 5'd9, 5'd9, 1'b1);
        for (int i = 0; i < 33; i++) cyc(1'b1, 1'b0, 5'd0, '0, 5'd9, 5'($urandom), 1'b0);

        // clr_req held high: back-to-back clears
        fill();
        for (int i = 0; i < 70; i++) rnd_rd(1'($urandom), 5'($urandom), N'($urandom), 1'b1);
        for (int i = 0; i < 3; i++) rnd_rd(1'b0, 5'd0, '0, 1'b0);

        // Random traffic with occasional clears and resets
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(0, 149) != 0), 1'($urandom), 5'($urandom),
                N'($urandom), 5'($urandom), 5'($urandom),
                ($urandom_range(0, 24) == 0));
        end

        repeat (3) @(negedge clk);
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameter N SHALL be declared: N, default 32, data width of each entry and each read/write port.
REQ-002 Port clk SHALL be: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port rst SHALL be: rst  input  1  asynchronous, active-low reset.
REQ-004 Port wr_ena SHALL be: wr_ena  input  1  write enable.
REQ-005 Port wr_addr SHALL be: wr_addr  input  5  write entry index.
REQ-006 Port wr_data SHALL be: wr_data  input  N  write data.
REQ-007 Port rd_addr0 SHALL be: rd_addr0  input  5  read port 0 entry index.
REQ-008 Port rd_data0 SHALL be: rd_data0  output  N  read port 0 data.
REQ-009 Port rd_addr1 SHALL be: rd_addr1  input  5  read port 1 entry index.
REQ-010 Port rd_data1 SHALL be: rd_data1  output  N  read port 1 data.
REQ-011 Port clr_req SHALL be: clr_req  input  1  request sequential clear of all entries.
REQ-012 Port busy SHALL be: busy  output  1  high while a clear is in progress.
REQ-013 Port clr_done SHALL be: clr_done  output  1  one-cycle pulse when a clear completes.

Function
REQ-014 Storage SHALL be 32 entries of N bits; entry 0 SHALL always read as zero and SHALL never be written.
REQ-015 Read ports SHALL be combinational: rd_dataK SHALL equal entry[rd_addrK] in the same cycle, zero latency; both ports SHALL be independent and may address the same entry.
REQ-016 A write SHALL occur at the rising edge when wr_ena=1, wr_addr!=0 and state=IDLE; the new value SHALL be visible on read ports the cycle after the edge.
REQ-017 Read-during-write to the same address SHALL return the old value until the edge.
REQ-018 The FSM SHALL have two states: IDLE and CLEARING.
REQ-019 IDLE -> CLEARING SHALL occur at the edge where clr_req=1 in IDLE; the clear counter SHALL load 1.
REQ-020 In CLEARING, each edge SHALL zero entry[counter] and increment counter; entries 1..31 SHALL be cleared in order over exactly 31 cycles.
REQ-021 At the edge that zeroes entry 31, the FSM SHALL return to IDLE, counter SHALL return to 0, and clr_done SHALL be 1 for the following cycle only.
REQ-022 busy SHALL equal 1 exactly while state=CLEARING (registered, 31 cycles per clear).
REQ-023 In CLEARING, wr_ena SHALL be ignored (write dropped, not queued); clr_req SHALL be ignored.
REQ-024 In CLEARING, reads SHALL remain valid and reflect the partially cleared contents.
REQ-025 Simultaneous wr_ena and clr_req in IDLE: the write SHALL commit at that edge, then the clear SHALL start and eventually zero that entry.
REQ-026 clr_req held high across clr_done SHALL start a new clear at the edge where state is IDLE again (back-to-back clears permitted, busy low for at least one cycle between them).

Reset
REQ-027 While rst=0, regardless of clk: all entries SHALL be 0, state SHALL be IDLE, counter 0, busy 0, clr_done 0, so rd_data0/rd_data1 read 0.
REQ-028 Reset asserted mid-clear SHALL abort the clear immediately with no clr_done pulse; after deassertion the block SHALL be in IDLE accepting writes on the first edge.

Verification
REQ-029 Scenario: after reset, write 0xDEADBEEF to addr 5 then read rd_addr0=5 -> 0xDEADBEEF on the next cycle; rd_addr1=5 in the write cycle -> 0.
REQ-030 Scenario: write 0x12345678 to addr 0, read addr 0 on both ports -> 0x00000000.
REQ-031 Scenario: fill entries 1..31 with value i, pulse clr_req -> busy high exactly 31 cycles, entry k reads 0 after cycle k, clr_done one-cycle pulse, all reads 0 afterwards.
REQ-032 Scenario: wr_ena to addr 7 with 0xA5A5A5A5 during CLEARING at counter=3 -> entry 7 reads 0 after clear completes, write never visible.
REQ-033 Scenario: rst=0 asserted at counter=10 with entries 20..31 nonzero -> all reads 0 immediately, busy 0, no clr_done; write to addr 3 on first post-reset edge succeeds.
REQ-034 Scenario: wr_ena (addr 9, 0x1) and clr_req in the same IDLE cycle -> entry 9 reads 0x1 until counter passes 9, then 0.
